// File: rtl/sum_accumulator_pkg.sv
// Shared FSM encodings and default widths for the sum accumulator slice.
package sum_accumulator_pkg;

  typedef enum logic {
    ACC = 1'b0,
    OUT = 1'b1
  } state_t;

  localparam int DEF_IN_W      = 4;
  localparam int DEF_ACC_W     = 8;
  localparam int DEF_N_SAMPLES = 4;

endpackage

// File: rtl/sum_accumulator_adder.sv
// Ripple-carry adder built from full_adder cells with carry-in tied low.
// Purely combinational, no backpressure.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

module acc_ripple_adder #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         cout
);

  logic [W:0] c;

  assign c[0] = 1'b0;

  for (genvar i = 0; i < W; i++) begin : g_fa
    full_adder u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (c[i]),
      .sum  (sum[i]),
      .cout (c[i+1])
    );
  end

  assign cout = c[W];

endmodule

// File: rtl/sum_accumulator.sv
// Accumulates N_SAMPLES handshaked sums into a group total with sticky overflow; result valid the
// cycle after the Nth accept, held until out_ready; no input is accepted while a result is pending.
module sum_accumulator
  import sum_accumulator_pkg::*;
#(
  parameter int IN_W      = DEF_IN_W,
  parameter int ACC_W     = DEF_ACC_W,
  parameter int N_SAMPLES = DEF_N_SAMPLES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_sum,
  input  logic             in_clear,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_total,
  output logic             out_ovf
);

  localparam int              CNT_W = $clog2(N_SAMPLES + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_SAMPLES - 1);

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] sum;
  logic             carry;
  logic             ovf;
  logic [CNT_W-1:0] count;
  logic             accept;

  acc_ripple_adder #(.W(ACC_W)) u_adder (
    .a    (acc),
    .b    (ACC_W'(in_sum)),
    .sum  (sum),
    .cout (carry)
  );

  // Held low while rst is asserted so upstream never sees a ready during reset.
  assign in_ready = (state == ACC) && !rst;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ACC;
      acc       <= '0;
      count     <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
      out_total <= '0;
      out_ovf   <= 1'b0;
    end else if (in_clear) begin
      state     <= ACC;
      acc       <= '0;
      count     <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        ACC: begin
          if (accept) begin
            if (count == LAST) begin
              out_total <= sum;
              out_ovf   <= ovf | carry;
              out_valid <= 1'b1;
              acc       <= '0;
              count     <= '0;
              ovf       <= 1'b0;
              state     <= OUT;
            end else begin
              acc   <= sum;
              ovf   <= ovf | carry;
              count <= count + CNT_W'(1);
            end
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ACC;
          end
        end
        default: state <= ACC;
      endcase
    end
  end

endmodule
